// File: rtl/alu_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mdu_seq
// Purpose  : EX-stage ALU with a registered result stage and an iterative
//            multiply/divide unit that owns the architectural HI/LO pair.
//            Single-cycle ops return one cycle after acceptance and can issue
//            back to back. mult/multu/div/divu run one bit per clock for WIDTH
//            clocks and return on the RUN->DONE transition (WIDTH+1 latency).
// Ports    : clk, reset_n (async, active low)
//            in_valid/in_ready  - request handshake (in_ready = !busy)
//            Instruction        - opcode [31:26], funct [5:0]
//            A, B, shamt        - operands and shift amount
//            out_valid          - one-cycle pulse qualifying O/zero/illegal
//            O, zero, illegal   - registered result, O==0 flag, bad encoding
//            busy               - multiply/divide in progress
// Revision : 1.0 - initial release
// ============================================================================
module alu_mdu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        Instruction,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   O,
    output logic               zero,
    output logic               illegal,
    output logic               busy
);

    // Opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDIU = 6'b001001;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] c_FN_SLL   = 6'b000000;
    localparam logic [5:0] c_FN_SRL   = 6'b000010;
    localparam logic [5:0] c_FN_SRA   = 6'b000011;
    localparam logic [5:0] c_FN_MFHI  = 6'b010000;
    localparam logic [5:0] c_FN_MFLO  = 6'b010010;
    localparam logic [5:0] c_FN_MULT  = 6'b011000;
    localparam logic [5:0] c_FN_MULTU = 6'b011001;
    localparam logic [5:0] c_FN_DIV   = 6'b011010;
    localparam logic [5:0] c_FN_DIVU  = 6'b011011;
    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_XOR   = 6'b100110;
    localparam logic [5:0] c_FN_NOR   = 6'b100111;
    localparam logic [5:0] c_FN_NOR2  = 6'b101111;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;
    localparam logic [5:0] c_FN_SLTU  = 6'b101011;

    // Multiply/divide sequencer states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam int                 c_CNT_W   = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_TOP = c_CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic               r_busy;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_o;
    logic               r_zero;
    logic               r_illegal;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    // Iteration state: {r_rem, r_quo} is the partial product for multiply and
    // the partial remainder / shifting dividend-quotient for divide.
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_opnd;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_a_raw;    // original dividend, returned as HI on /0
    logic [c_CNT_W-1:0] r_count;
    logic               r_is_div;
    logic               r_neg_q;    // negate product / quotient at the end
    logic               r_neg_r;    // negate remainder at the end
    logic               r_div0;

    // ------------------------------------------------------------------------
    // Decode and single-cycle datapath
    // ------------------------------------------------------------------------
    logic [5:0]       w_opcode;
    logic [5:0]       w_funct;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_slt;
    logic [WIDTH-1:0] w_sltu;
    logic [WIDTH-1:0] w_res;
    logic             w_ill;
    logic             w_md;
    logic             w_md_div;
    logic             w_md_signed;
    logic             w_accept;
    logic             w_unused_instr;

    assign w_opcode       = Instruction[31:26];
    assign w_funct        = Instruction[5:0];
    assign w_unused_instr = ^Instruction[25:6];
    assign w_sum          = A + B;
    assign w_diff         = A - B;
    assign w_slt          = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
    assign w_sltu         = {{(WIDTH-1){1'b0}}, (A < B)};
    assign w_accept       = in_valid & ~r_busy;

    always_comb begin
        w_res       = '0;
        w_ill       = 1'b0;
        w_md        = 1'b0;
        w_md_div    = 1'b0;
        w_md_signed = 1'b0;
        case (w_opcode)
            c_OP_RTYPE: begin
                case (w_funct)
                    c_FN_ADDU:            w_res = w_sum;
                    c_FN_SUBU:            w_res = w_diff;
                    c_FN_AND:             w_res = A & B;
                    c_FN_OR:              w_res = A | B;
                    c_FN_XOR:             w_res = A ^ B;
                    c_FN_NOR, c_FN_NOR2:  w_res = ~(A | B);
                    c_FN_SLL:             w_res = B << shamt;
                    c_FN_SRL:             w_res = B >> shamt;
                    c_FN_SRA:             w_res = $signed(B) >>> shamt;
                    c_FN_SLT:             w_res = w_slt;
                    c_FN_SLTU:            w_res = w_sltu;
                    c_FN_MFHI:            w_res = r_hi;
                    c_FN_MFLO:            w_res = r_lo;
                    c_FN_MULT: begin
                        w_md        = 1'b1;
                        w_md_signed = 1'b1;
                    end
                    c_FN_MULTU: begin
                        w_md        = 1'b1;
                    end
                    c_FN_DIV: begin
                        w_md        = 1'b1;
                        w_md_div    = 1'b1;
                        w_md_signed = 1'b1;
                    end
                    c_FN_DIVU: begin
                        w_md        = 1'b1;
                        w_md_div    = 1'b1;
                    end
                    default:              w_ill = 1'b1;
                endcase
            end
            c_OP_ADDIU, c_OP_LW, c_OP_SW: w_res = w_sum;
            c_OP_ANDI:                    w_res = A & B;
            c_OP_SLTI:                    w_res = w_slt;
            c_OP_BEQ, c_OP_BNE:           w_res = w_diff;
            default:                      w_ill = 1'b1;
        endcase
    end

    // Operand magnitudes; both unsigned variants pass operands through.
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_a_neg = w_md_signed & A[WIDTH-1];
    assign w_b_neg = w_md_signed & B[WIDTH-1];
    assign w_a_mag = w_a_neg ? (-A) : A;
    assign w_b_mag = w_b_neg ? (-B) : B;

    // ------------------------------------------------------------------------
    // One iteration of shift-add multiply / restoring divide
    // ------------------------------------------------------------------------
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_rem;
    logic [WIDTH-1:0] w_mul_quo;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_trial;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_quo;

    // Multiply: add the multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole {carry, upper, lower} right.
    assign w_mul_sum = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_rem = w_mul_sum[WIDTH:1];
    assign w_mul_quo = {w_mul_sum[0], r_quo[WIDTH-1:1]};

    // Divide: shift the next dividend bit into the remainder and keep the
    // trial subtraction only if it did not borrow. The remainder stays below
    // the divisor, so the shifted value never needs more than WIDTH+1 bits.
    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_opnd};
    assign w_div_ok    = ~w_div_trial[WIDTH];
    assign w_div_rem   = w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_div_quo   = {r_quo[WIDTH-2:0], w_div_ok};

    assign w_step_rem = r_is_div ? w_div_rem : w_mul_rem;
    assign w_step_quo = r_is_div ? w_div_quo : w_mul_quo;

    // Final sign correction applied to the last step's output, so HI/LO are
    // written on the same edge that leaves RUN.
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_hi_fin;
    logic [WIDTH-1:0]   w_lo_fin;

    assign w_prod     = {w_step_rem, w_step_quo};
    assign w_prod_fix = r_neg_q ? (-w_prod) : w_prod;

    always_comb begin
        w_hi_fin = w_prod_fix[2*WIDTH-1:WIDTH];
        w_lo_fin = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            if (r_div0) begin
                w_hi_fin = r_a_raw;
                w_lo_fin = '1;
            end else begin
                // MIN / -1 falls out naturally: the quotient magnitude 2^(W-1)
                // negates back to MIN and the remainder is zero.
                w_hi_fin = r_neg_r ? (-w_step_rem) : w_step_rem;
                w_lo_fin = r_neg_q ? (-w_step_quo) : w_step_quo;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer and registered result stage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_ST_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_o         <= '0;
            r_zero      <= 1'b1;
            r_illegal   <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_opnd      <= '0;
            r_a_raw     <= '0;
            r_count     <= '0;
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_div0      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_md) begin
                            r_state  <= c_ST_RUN;
                            r_busy   <= 1'b1;
                            r_rem    <= '0;
                            r_quo    <= w_a_mag;
                            r_opnd   <= w_b_mag;
                            r_a_raw  <= A;
                            r_count  <= c_CNT_TOP;
                            r_is_div <= w_md_div;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_div0   <= (B == '0);
                        end else begin
                            r_out_valid <= 1'b1;
                            r_o         <= w_res;
                            r_zero      <= (w_res == '0);
                            r_illegal   <= w_ill;
                        end
                    end
                end
                c_ST_RUN: begin
                    r_rem <= w_step_rem;
                    r_quo <= w_step_quo;
                    if (r_count == '0) begin
                        r_state     <= c_ST_DONE;
                        r_hi        <= w_hi_fin;
                        r_lo        <= w_lo_fin;
                        r_out_valid <= 1'b1;
                        r_o         <= w_lo_fin;
                        r_zero      <= (w_lo_fin == '0);
                        r_illegal   <= 1'b0;
                    end else begin
                        r_count <= r_count - c_CNT_ONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = ~r_busy;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign O         = r_o;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mdu_seq
// Purpose  : Scoreboard bench for alu_mdu_seq. Stimulus pushes hand-computed
//            expected results (value, illegal flag, arrival cycle) into a
//            queue per instance; monitors pop and compare on out_valid.
//            Instances: WIDTH=32 and WIDTH=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mdu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // 32-bit instance
    logic        v32, rdy32, ov32, z32, ill32, busy32;
    logic [31:0] ins32, a32, b32, o32;
    logic [4:0]  sh32;

    // 16-bit instance
    logic        v16, rdy16, ov16, z16, ill16, busy16;
    logic [31:0] ins16;
    logic [15:0] a16, b16, o16;
    logic [3:0]  sh16;

    alu_mdu_seq #(.WIDTH(32), .SHAMT_W(5)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .in_valid(v32), .in_ready(rdy32),
        .Instruction(ins32), .A(a32), .B(b32), .shamt(sh32),
        .out_valid(ov32), .O(o32), .zero(z32), .illegal(ill32), .busy(busy32)
    );

    alu_mdu_seq #(.WIDTH(16), .SHAMT_W(4)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .in_valid(v16), .in_ready(rdy16),
        .Instruction(ins16), .A(a16), .B(b16), .shamt(sh16),
        .out_valid(ov16), .O(o16), .zero(z16), .illegal(ill16), .busy(busy16)
    );

    typedef struct {
        logic [31:0] o;
        logic        ill;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rt(input logic [5:0] fn);
        return {26'd0, fn};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] op);
        return {op, 26'd0};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic score(input bit w16, input logic [31:0] got_o, input logic got_z,
                         input logic got_ill);
        exp_t e;
        logic exp_z;
        n_cmp++;
        if ((w16 && q16.size() == 0) || (!w16 && q32.size() == 0)) begin
            n_fail++;
            $display("FAIL unexpected_out_valid_w%0d: got out_valid with O=%h at cycle %0d, required no output",
                     w16 ? 16 : 32, got_o, cyc);
            return;
        end
        if (w16) e = q16.pop_front();
        else     e = q32.pop_front();
        exp_z = (e.o == 32'h0);
        if (got_o !== e.o || got_z !== exp_z || got_ill !== e.ill || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL %s: got O=%h zero=%b illegal=%b cycle=%0d, required O=%h zero=%b illegal=%b cycle=%0d",
                     e.name, got_o, got_z, got_ill, cyc, e.o, exp_z, e.ill, e.cyc);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        if (ov32 === 1'b1) score(1'b0, o32, z32, ill32);
        if (ov16 === 1'b1) score(1'b1, {16'h0, o16}, z16, ill16);
    end

    // Issue one operation at the current negedge; returns one negedge later.
    task automatic issue(input bit w16, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input int sh, input logic [31:0] exp_o,
                         input logic exp_ill, input int lat, input bit expect_out,
                         input string name);
        int   waitc;
        exp_t e;
        waitc = 0;
        while (!(w16 ? rdy16 : rdy32)) begin
            if (waitc == 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s_ready_timeout: in_ready low for %0d cycles, required 1", name, waitc);
                return;
            end
            @(negedge clk);
            waitc++;
        end
        if (w16) begin
            v16 = 1'b1; ins16 = ins; a16 = a[15:0]; b16 = b[15:0]; sh16 = sh[3:0];
        end else begin
            v32 = 1'b1; ins32 = ins; a32 = a; b32 = b; sh32 = sh[4:0];
        end
        if (expect_out) begin
            e.o = exp_o; e.ill = exp_ill; e.cyc = cyc + lat; e.name = name;
            if (w16) q16.push_back(e);
            else     q32.push_back(e);
        end
        @(negedge clk);
        if (w16) v16 = 1'b0;
        else     v32 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int   cnt;
        exp_t e;
        reset_n = 1'b0;
        v32 = 1'b0; ins32 = '0; a32 = '0; b32 = '0; sh32 = '0;
        v16 = 1'b0; ins16 = '0; a16 = '0; b16 = '0; sh16 = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset_O", o32, 32'h0);
        chk("reset_zero", {31'd0, z32}, 32'd1);
        chk("reset_out_valid", {31'd0, ov32}, 32'd0);
        chk("reset_illegal", {31'd0, ill32}, 32'd0);
        chk("reset_busy", {31'd0, busy32}, 32'd0);
        chk("reset_in_ready", {31'd0, rdy32}, 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Single-cycle ops
        issue(0, rt(6'h21), 32'hFFFFFFFF, 32'h1, 0, 32'h0, 0, 1, 1, "addu_wrap");
        issue(0, rt(6'h23), 32'h5, 32'h7, 0, 32'hFFFFFFFE, 0, 1, 1, "subu_b2b");
        issue(0, rt(6'h03), 32'h0, 32'h80000000, 4, 32'hF8000000, 0, 1, 1, "sra_b2b");
        issue(0, rt(6'h2A), 32'hFFFFFFFF, 32'h1, 0, 32'h1, 0, 1, 1, "slt_b2b");
        repeat (2) @(negedge clk);
        chk("hold_O_idle", o32, 32'h1);
        chk("hold_out_valid_idle", {31'd0, ov32}, 32'd0);

        issue(0, rt(6'h24), 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hF000F000, 0, 1, 1, "and");
        issue(0, rt(6'h25), 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hFFF0FFF0, 0, 1, 1, "or");
        issue(0, rt(6'h26), 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h0FF00FF0, 0, 1, 1, "xor");
        issue(0, rt(6'h27), 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h000F000F, 0, 1, 1, "nor");
        issue(0, rt(6'h2F), 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h000F000F, 0, 1, 1, "nor_alt");
        issue(0, rt(6'h00), 32'h0, 32'h1, 31, 32'h80000000, 0, 1, 1, "sll_31");
        issue(0, rt(6'h02), 32'h0, 32'h80000000, 31, 32'h1, 0, 1, 1, "srl_31");
        issue(0, rt(6'h2B), 32'hFFFFFFFF, 32'h1, 0, 32'h0, 0, 1, 1, "sltu");
        issue(0, it(6'h09), 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 1, 1, "addiu");
        issue(0, it(6'h0C), 32'h12345678, 32'h0000FFFF, 0, 32'h00005678, 0, 1, 1, "andi");
        issue(0, it(6'h0A), 32'hFFFFFFFF, 32'h1, 0, 32'h1, 0, 1, 1, "slti");
        issue(0, it(6'h04), 32'h5, 32'h5, 0, 32'h0, 0, 1, 1, "beq_equal");
        issue(0, it(6'h05), 32'h5, 32'h3, 0, 32'h2, 0, 1, 1, "bne");
        issue(0, it(6'h23), 32'h1000, 32'hFFFFFFFC, 0, 32'h00000FFC, 0, 1, 1, "lw");
        issue(0, it(6'h2B), 32'h8, 32'h8, 0, 32'h10, 0, 1, 1, "sw");
        issue(0, rt(6'h3F), 32'h1, 32'h2, 0, 32'h0, 1, 1, 1, "illegal_funct");
        issue(0, rt(6'h20), 32'h1, 32'h2, 0, 32'h0, 1, 1, 1, "illegal_funct_add");
        issue(0, it(6'h3F), 32'h1, 32'h2, 0, 32'h0, 1, 1, 1, "illegal_opcode");
        issue(0, rt(6'h21), 32'h2, 32'h3, 0, 32'h5, 0, 1, 1, "addu_after_illegal");

        // Signed multiply with in_ready low-time measurement
        issue(0, rt(6'h18), 32'hFFFFFFFD, 32'h7, 0, 32'hFFFFFFEB, 0, 33, 1, "mult_neg");
        cnt = 0;
        while (!rdy32 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("mult_in_ready_low_cycles", cnt, 33);
        issue(0, rt(6'h10), 32'h0, 32'h0, 0, 32'hFFFFFFFF, 0, 1, 1, "mfhi_after_mult");
        issue(0, rt(6'h12), 32'h0, 32'h0, 0, 32'hFFFFFFEB, 0, 1, 1, "mflo_after_mult");

        issue(0, rt(6'h19), 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h1, 0, 33, 1, "multu_max");
        issue(0, rt(6'h10), 32'h0, 32'h0, 0, 32'hFFFFFFFE, 0, 1, 1, "mfhi_after_multu");

        issue(0, rt(6'h1A), 32'hFFFFFFF9, 32'h2, 0, 32'hFFFFFFFD, 0, 33, 1, "div_neg_pos");
        issue(0, rt(6'h10), 32'h0, 32'h0, 0, 32'hFFFFFFFF, 0, 1, 1, "mfhi_div_neg_pos");
        issue(0, rt(6'h1A), 32'h7, 32'hFFFFFFFE, 0, 32'hFFFFFFFD, 0, 33, 1, "div_pos_neg");
        issue(0, rt(6'h10), 32'h0, 32'h0, 0, 32'h1, 0, 1, 1, "mfhi_div_pos_neg");
        issue(0, rt(6'h1A), 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0, 33, 1, "div_overflow");
        issue(0, rt(6'h10), 32'h0, 32'h0, 0, 32'h0, 0, 1, 1, "mfhi_div_overflow");
        issue(0, rt(6'h1B), 32'h9, 32'h0, 0, 32'hFFFFFFFF, 0, 33, 1, "divu_by_zero");
        issue(0, rt(6'h10), 32'h0, 32'h0, 0, 32'h9, 0, 1, 1, "mfhi_divu_by_zero");
        issue(0, rt(6'h1A), 32'hFFFFFFF9, 32'h0, 0, 32'hFFFFFFFF, 0, 33, 1, "div_by_zero");
        issue(0, rt(6'h10), 32'h0, 32'h0, 0, 32'hFFFFFFF9, 0, 1, 1, "mfhi_div_by_zero");
        issue(0, rt(6'h1B), 32'd100, 32'd7, 0, 32'd14, 0, 33, 1, "divu_100_7");
        issue(0, rt(6'h10), 32'h0, 32'h0, 0, 32'd2, 0, 1, 1, "mfhi_divu_100_7");

        // Reset during RUN: no result, HI/LO cleared
        issue(0, rt(6'h19), 32'h12345678, 32'h9ABCDEF0, 0, 32'h0, 0, 33, 0, "multu_aborted");
        repeat (9) @(negedge clk);
        chk("busy_before_abort", {31'd0, busy32}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy32}, 32'd0);
        chk("abort_in_ready", {31'd0, rdy32}, 32'd1);
        chk("abort_out_valid", {31'd0, ov32}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue(0, rt(6'h10), 32'h0, 32'h0, 0, 32'h0, 0, 1, 1, "mfhi_after_abort");
        issue(0, rt(6'h12), 32'h0, 32'h0, 0, 32'h0, 0, 1, 1, "mflo_after_abort");

        // 16-bit instance: latency WIDTH+1 = 17
        issue(1, rt(6'h18), 32'h0000FFFD, 32'h7, 0, 32'h0000FFEB, 0, 17, 1, "mult_w16");
        issue(1, rt(6'h10), 32'h0, 32'h0, 0, 32'h0000FFFF, 0, 1, 1, "mfhi_w16");

        // Drain
        cnt = 0;
        while ((q32.size() != 0 || q16.size() != 0) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        while (q32.size() != 0) begin
            e = q32.pop_front();
            n_cmp++; n_fail++;
            $display("FAIL %s_missing: got no out_valid, required O=%h", e.name, e.o);
        end
        while (q16.size() != 0) begin
            e = q16.pop_front();
            n_cmp++; n_fail++;
            $display("FAIL %s_missing: got no out_valid, required O=%h", e.name, e.o);
        end
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
